// File: rtl/stripe_bus_sched.sv
// Round-robin owner of the shared tag/stride/operand bus: grants one stripe
// a fixed-length burst, gates router beats to it, and pulses serv/abort.
module stripe_bus_sched #(
  parameter int n_req     = 8,
  parameter int idx_width = 3,
  parameter int burst_len = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n_req-1:0]     req,
  input  logic                 src_valid,
  output logic [n_req-1:0]     grant,
  output logic [idx_width-1:0] grant_idx,
  output logic                 active,
  output logic                 beat_en,
  output logic                 beat_last,
  output logic [7:0]           beat_cnt,
  output logic [n_req-1:0]     serv,
  output logic [n_req-1:0]     abort
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0]           LAST_BEAT = 8'(burst_len - 1);
  localparam logic [idx_width-1:0] LAST_RST  = idx_width'(n_req - 1);

  state_t               state_q;
  logic [n_req-1:0]     grant_q;
  logic [idx_width-1:0] grant_idx_q;
  logic                 active_q;
  logic [7:0]           beat_cnt_q;
  logic [n_req-1:0]     serv_q;
  logic [n_req-1:0]     abort_q;
  logic [idx_width-1:0] last_q;

  logic [idx_width-1:0] win_idx_d;
  logic                 win_vld_d;
  logic                 owner_req_s;
  logic                 final_beat_s;

  // Rotating scan: first requester after the most recent winner.
  always_comb begin
    win_idx_d = {idx_width{1'b0}};
    win_vld_d = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      int p;
      p = (int'(last_q) + k) % n_req;
      if (!win_vld_d && req[p]) begin
        win_vld_d = 1'b1;
        win_idx_d = idx_width'(p);
      end else begin
        win_vld_d = win_vld_d;
      end
    end
  end

  assign owner_req_s  = req[grant_idx_q];
  assign final_beat_s = src_valid && (beat_cnt_q == LAST_BEAT);

  // Sequencer: IDLE samples requests, GRANT runs the burst, GAP shows the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= {n_req{1'b0}};
      grant_idx_q <= {idx_width{1'b0}};
      active_q    <= 1'b0;
      beat_cnt_q  <= 8'd0;
      serv_q      <= {n_req{1'b0}};
      abort_q     <= {n_req{1'b0}};
      last_q      <= LAST_RST;
    end else begin
      serv_q  <= {n_req{1'b0}};
      abort_q <= {n_req{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            grant_q     <= n_req'(1'b1) << win_idx_d;
            grant_idx_q <= win_idx_d;
            active_q    <= 1'b1;
            beat_cnt_q  <= 8'd0;
            state_q     <= ST_GRANT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (src_valid) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
          end else begin
            beat_cnt_q <= beat_cnt_q;
          end
          // A dropped request wins over a coincident final beat.
          if (!owner_req_s) begin
            abort_q[grant_idx_q] <= 1'b1;
            last_q               <= grant_idx_q;
            grant_q              <= {n_req{1'b0}};
            active_q             <= 1'b0;
            state_q              <= ST_GAP;
          end else if (final_beat_s) begin
            serv_q[grant_idx_q] <= 1'b1;
            last_q              <= grant_idx_q;
            grant_q             <= {n_req{1'b0}};
            active_q            <= 1'b0;
            state_q             <= ST_GAP;
          end else begin
            state_q <= ST_GRANT;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          grant_q  <= {n_req{1'b0}};
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign active    = active_q;
  assign beat_cnt  = beat_cnt_q;
  assign serv      = serv_q;
  assign abort     = abort_q;
  assign beat_en   = active_q & src_valid;
  // The owner's request gates only the final-beat flag, so an abort never looks like a completion.
  assign beat_last = beat_en & (beat_cnt_q == LAST_BEAT) & owner_req_s;

endmodule

// File: tb/tb_stripe_bus_sched.sv
// Directed bench for stripe_bus_sched: reset, single burst, round-robin order,
// stall, abort, abort on final beat and mid-burst reset.
module tb_stripe_bus_sched;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       src_valid;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       active;
  logic       beat_en;
  logic       beat_last;
  logic [7:0] beat_cnt;
  logic [7:0] serv;
  logic [7:0] abort;

  int n_checks;
  int n_fail;

  stripe_bus_sched #(.n_req(8), .idx_width(3), .burst_len(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .src_valid (src_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .active    (active),
    .beat_en   (beat_en),
    .beat_last (beat_last),
    .beat_cnt  (beat_cnt),
    .serv      (serv),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic v);
    req       = r;
    src_valid = v;
    #1;
  endtask

  logic [1:0] stall_pat [6];
  logic [7:0] stall_cnt [6];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 8'h00;
    src_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values, src_valid high while idle must not strobe
    drive(8'h00, 1'b1);
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_idx", 32'(grant_idx), 32'h0);
    check_val("rst_active", 32'(active), 32'h0);
    check_val("rst_cnt", 32'(beat_cnt), 32'h0);
    check_val("rst_serv", 32'(serv), 32'h0);
    check_val("rst_abort", 32'(abort), 32'h0);
    check_val("rst_beat_en", 32'(beat_en), 32'h0);

    // Single request on index 2
    drive(8'h04, 1'b1);
    check_val("s1_idle_grant", 32'(grant), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("s1_grant", 32'(grant), 32'h04);
      check_val("s1_active", 32'(active), 32'h1);
      check_val("s1_beat_en", 32'(beat_en), 32'h1);
      check_val("s1_cnt", 32'(beat_cnt), 32'(i));
      check_val("s1_last", 32'(beat_last), (i == 3) ? 32'h1 : 32'h0);
      tick();
    end
    drive(8'h00, 1'b1);
    check_val("s1_gap_grant", 32'(grant), 32'h0);
    check_val("s1_gap_active", 32'(active), 32'h0);
    check_val("s1_gap_serv", 32'(serv), 32'h04);
    check_val("s1_gap_abort", 32'(abort), 32'h0);
    tick();
    check_val("s1_idle_serv", 32'(serv), 32'h0);
    check_val("s1_idle_idx", 32'(grant_idx), 32'h2);

    // Reset again so round-robin starts at index 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(8'hFF, 1'b1);
    for (int b = 0; b < 9; b++) begin
      tick();
      check_val("rr_grant", 32'(grant), 32'h1 << (b % 8));
      check_val("rr_idx", 32'(grant_idx), 32'(b % 8));
      tick();
      tick();
      tick();
      check_val("rr_last", 32'(beat_last), 32'h1);
      tick();
      check_val("rr_serv", 32'(serv), 32'h1 << (b % 8));
      check_val("rr_gap_grant", 32'(grant), 32'h0);
      tick();
      check_val("rr_idle_grant", 32'(grant), 32'h0);
    end
    // last is now 0

    // Stall pattern on index 0
    stall_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    stall_cnt = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    drive(8'h01, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(8'h01, stall_pat[i][0]);
      check_val("st_grant", 32'(grant), 32'h01);
      check_val("st_cnt", 32'(beat_cnt), 32'(stall_cnt[i]));
      check_val("st_beat_en", 32'(beat_en), 32'(stall_pat[i][0]));
      check_val("st_last", 32'(beat_last), (i == 5) ? 32'h1 : 32'h0);
      tick();
    end
    drive(8'h00, 1'b0);
    check_val("st_serv", 32'(serv), 32'h01);
    tick();

    // Abort: index 3 drops after 2 beats
    drive(8'h08, 1'b1);
    tick();
    check_val("ab_idx", 32'(grant_idx), 32'h3);
    tick();
    tick();
    drive(8'h00, 1'b1);
    check_val("ab_beat_en", 32'(beat_en), 32'h1);
    check_val("ab_last", 32'(beat_last), 32'h0);
    tick();
    drive(8'h18, 1'b1);
    check_val("ab_abort", 32'(abort), 32'h08);
    check_val("ab_serv", 32'(serv), 32'h0);
    check_val("ab_grant", 32'(grant), 32'h0);
    tick();
    tick();
    check_val("ab_next_idx", 32'(grant_idx), 32'h4);
    check_val("ab_next_grant", 32'(grant), 32'h10);
    drive(8'h00, 1'b1);
    tick();
    check_val("ab2_abort", 32'(abort), 32'h10);
    tick();

    // Abort coinciding with the final beat of index 5
    drive(8'h20, 1'b1);
    tick();
    check_val("af_idx", 32'(grant_idx), 32'h5);
    tick();
    tick();
    tick();
    drive(8'h00, 1'b1);
    check_val("af_cnt", 32'(beat_cnt), 32'h3);
    check_val("af_beat_en", 32'(beat_en), 32'h1);
    check_val("af_last", 32'(beat_last), 32'h0);
    tick();
    check_val("af_abort", 32'(abort), 32'h20);
    check_val("af_serv", 32'(serv), 32'h0);
    tick();

    // Reset during beat 2 of a grant to index 6
    drive(8'h40, 1'b1);
    tick();
    check_val("mr_idx", 32'(grant_idx), 32'h6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(8'hC0, 1'b1);
    check_val("mr_grant", 32'(grant), 32'h0);
    check_val("mr_cnt", 32'(beat_cnt), 32'h0);
    check_val("mr_active", 32'(active), 32'h0);
    check_val("mr_serv", 32'(serv), 32'h0);
    check_val("mr_abort", 32'(abort), 32'h0);
    check_val("mr_idx0", 32'(grant_idx), 32'h0);
    tick();
    check_val("mr_next_grant", 32'(grant), 32'h40);
    check_val("mr_next_idx", 32'(grant_idx), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
